cp0_exc_unit: RTL and testbench

Parametrised coprocessor-0 for the MIPS core: holds BadVAddr, Count, Compare, Status, Cause and EPC. It adds a free-running Count/Compare timer, sampling of NUM_HW_INT hardware interrupt lines and a masked interrupt request. It also owns exception entry and ERET state updates, with fixed priority between exception, ERET and MTC0. It sits beside the register file; the pipeline drives it from the MEM/WB boundary and reads it for MFC0 and exception redirect.

---
 rtl/cp0_pkg.sv | 57 +++++
 rtl/cp0_exc_unit_timer.sv | 80 ++++++++
 rtl/cp0_exc_unit.sv | 155 +++++++++++++++
 tb/tb_cp0_exc_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared definitions for the coprocessor-0 exception unit.
// Holds CP0 register numbers, Status/Cause bit positions, ExcCode values,
// the MTC0 write masks and a helper that packs the Cause register.
package cp0_pkg;

    // CP0 register numbers (rd field of MTC0/MFC0)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Status bit positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_BEV   = 22;

    // Cause bit positions
    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;
    localparam int CA_IP_LO  = 8;
    localparam int CA_EXC_LO = 2;

    // Exception codes
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Bits that MTC0 may write: Status {BEV, IM, EXL, IE}, Cause IP[1:0]
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    // Pack the Cause register from its fields; unlisted bits are zero.
    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [7:0] ip,
        input logic [4:0] exc_code
    );
        logic [31:0] c;
        c                           = 32'h0000_0000;
        c[CA_BD]                    = bd;
        c[CA_TI]                    = ti;
        c[CA_IP_LO+7:CA_IP_LO]      = ip;
        c[CA_EXC_LO+4:CA_EXC_LO]    = exc_code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer for CP0.
// Ports: clk, rst_n (async active-low), count_we_i/compare_we_i load strobes
// with wdata_i, count_o/compare_o current values, ti_o timer interrupt flag.
// Count advances once every COUNT_DIV clocks; TI latches on Count==Compare.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      count_q, count_d;
    logic [31:0]      compare_q, compare_d;
    logic             ti_q, ti_d;
    logic             div_wrap_s;

    // Next-state for divider, Count, Compare and TI
    always_comb begin
        div_d      = div_q;
        count_d    = count_q;
        compare_d  = compare_q;
        ti_d       = ti_q;
        div_wrap_s = (div_q == DIV_LAST);

        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = {DIV_W{1'b0}};
        end else if (div_wrap_s) begin
            count_d = count_q + 32'd1;
            div_d   = {DIV_W{1'b0}};
        end else begin
            div_d   = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end

        if (compare_we_i) begin
            compare_d = wdata_i;
        end else begin
            compare_d = compare_q;
        end

        // A Compare write clears TI even if the match happens the same cycle
        if (compare_we_i) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= {DIV_W{1'b0}};
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// Coprocessor-0: BadVAddr, Count, Compare, Status, Cause, EPC.
// Ports: clk, rst_n (async active-low); MTC0 write (mtc0_we_i, rd_i, wdata_i);
// MFC0 read rdata_o (combinational from rd_i); hw_int_i interrupt lines;
// exception commit (exc_valid_i, exc_code_i, exc_pc_i, exc_bd_i,
// exc_badvaddr_we_i, exc_badvaddr_i); eret_i; int_req_o; epc/status/cause outs.
// Same-cycle priority: exception > ERET > MTC0. Timer and IP sampling always run.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 2,
    parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mtc0_we_i,
    input  logic [4:0]            rd_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o,
    input  logic [NUM_HW_INT-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic                  exc_badvaddr_we_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic                  int_req_o,
    output logic [31:0]           epc_out_o,
    output logic [31:0]           status_out_o,
    output logic [31:0]           cause_out_o
);

    logic [31:0]           status_q, status_d;
    logic [31:0]           epc_q, epc_d;
    logic [31:0]           badvaddr_q, badvaddr_d;
    logic                  bd_q, bd_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic [1:0]            sw_ip_q, sw_ip_d;
    logic [NUM_HW_INT-1:0] hw_q;

    logic                  mtc0_win_s;
    logic [31:0]           count_s, compare_s, cause_s;
    logic                  ti_s;
    logic [7:0]            ip_s;

    // MTC0 only takes effect when no exception or ERET commits this cycle
    assign mtc0_win_s = mtc0_we_i & ~exc_valid_i & ~eret_i;

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .count_we_i   (mtc0_win_s && (rd_i == CP0_COUNT)),
        .compare_we_i (mtc0_win_s && (rd_i == CP0_COMPARE)),
        .wdata_i      (wdata_i),
        .count_o      (count_s),
        .compare_o    (compare_s),
        .ti_o         (ti_s)
    );

    // Interrupt-pending vector; with six hardware lines the top line shares IP[7] with TI
    always_comb begin
        ip_s      = 8'h00;
        ip_s[1:0] = sw_ip_q;
        for (int i = 0; i < NUM_HW_INT; i++) begin
            ip_s[2+i] = hw_q[i];
        end
        ip_s[7] = ip_s[7] | ti_s;
    end

    assign cause_s = pack_cause(bd_q, ti_s, ip_s, exc_code_q);

    // Next-state for exception entry, ERET and MTC0 writes
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exc_code_d = exc_code_q;
        sw_ip_d    = sw_ip_q;

        if (exc_valid_i) begin
            status_d[ST_EXL] = 1'b1;
            exc_code_d       = exc_code_i;
            // A nested exception keeps the original return point
            if (!status_q[ST_EXL]) begin
                epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_d  = exc_bd_i;
            end else begin
                epc_d = epc_q;
                bd_d  = bd_q;
            end
            if (exc_badvaddr_we_i) begin
                badvaddr_d = exc_badvaddr_i;
            end else begin
                badvaddr_d = badvaddr_q;
            end
        end else if (eret_i) begin
            status_d[ST_EXL] = 1'b0;
        end else if (mtc0_we_i) begin
            case (rd_i)
                CP0_STATUS: status_d = wdata_i & STATUS_WMASK;
                CP0_CAUSE:  sw_ip_d  = wdata_i[CA_IP_LO+1:CA_IP_LO];
                CP0_EPC:    epc_d    = wdata_i;
                default:    status_d = status_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // Architectural state and hardware-interrupt sampling registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q   <= RESET_STATUS & STATUS_WMASK;
            epc_q      <= 32'h0000_0000;
            badvaddr_q <= 32'h0000_0000;
            bd_q       <= 1'b0;
            exc_code_q <= 5'd0;
            sw_ip_q    <= 2'b00;
            hw_q       <= {NUM_HW_INT{1'b0}};
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            exc_code_q <= exc_code_d;
            sw_ip_q    <= sw_ip_d;
            hw_q       <= hw_int_i;
        end
    end

    // MFC0 read mux
    always_comb begin
        rdata_o = 32'h0000_0000;
        case (rd_i)
            CP0_BADVADDR: rdata_o = badvaddr_q;
            CP0_COUNT:    rdata_o = count_s;
            CP0_COMPARE:  rdata_o = compare_s;
            CP0_STATUS:   rdata_o = status_q;
            CP0_CAUSE:    rdata_o = cause_s;
            CP0_EPC:      rdata_o = epc_q;
            default:      rdata_o = 32'h0000_0000;
        endcase
    end

    assign int_req_o    = status_q[ST_IE] & ~status_q[ST_EXL]
                        & (|(ip_s & status_q[ST_IM_LO+7:ST_IM_LO]));
    assign epc_out_o    = epc_q;
    assign status_out_o = status_q;
    assign cause_out_o  = cause_s;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the CP0 registers.
module tb_cp0_exc_unit;

    localparam int NUM_HW_INT = 6;
    localparam int COUNT_DIV  = 2;

    logic        clk;
    logic        rst_n;
    logic        mtc0_we;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hw_int;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_bv_we;
    logic [31:0] exc_bv;
    logic        eret;
    logic        int_req;
    logic [31:0] epc_out, status_out, cause_out;

    int checks   = 0;
    int failures = 0;

    cp0_exc_unit #(
        .NUM_HW_INT   (NUM_HW_INT),
        .COUNT_DIV    (COUNT_DIV),
        .RESET_STATUS (32'h0040_0000)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mtc0_we_i         (mtc0_we),
        .rd_i              (rd),
        .wdata_i           (wdata),
        .rdata_o           (rdata),
        .hw_int_i          (hw_int),
        .exc_valid_i       (exc_valid),
        .exc_code_i        (exc_code),
        .exc_pc_i          (exc_pc),
        .exc_bd_i          (exc_bd),
        .exc_badvaddr_we_i (exc_bv_we),
        .exc_badvaddr_i    (exc_bv),
        .eret_i            (eret),
        .int_req_o         (int_req),
        .epc_out_o         (epc_out),
        .status_out_o      (status_out),
        .cause_out_o       (cause_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0]     m_status, m_epc, m_badv, m_compare, m_base;
    longint unsigned m_cyc;
    logic            m_bd, m_ti;
    logic [4:0]      m_code;
    logic [1:0]      m_sw;
    logic [5:0]      m_hw;

    function automatic logic [31:0] m_count();
        return m_base + 32'(m_cyc / longint'(COUNT_DIV));
    endfunction

    function automatic logic [7:0] m_ip();
        return {m_ti | m_hw[5], m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
    endfunction

    function automatic logic m_int();
        return m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'h00);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        case (r)
            5'd8:    return m_badv;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_status  = 32'h0040_0000;
        m_epc     = 32'h0;
        m_badv    = 32'h0;
        m_compare = 32'hFFFF_FFFF;
        m_base    = 32'h0;
        m_cyc     = 0;
        m_bd      = 1'b0;
        m_ti      = 1'b0;
        m_code    = 5'd0;
        m_sw      = 2'b00;
        m_hw      = 6'b0;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        mtc0_we = 1'b0; rd = 5'd0; wdata = 32'h0;
        exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'h0; exc_bd = 1'b0;
        exc_bv_we = 1'b0; exc_bv = 32'h0; eret = 1'b0;
    endtask

    task automatic peek(input string name, input logic [4:0] r, input logic [31:0] exp);
        rd = r;
        #1;
        check32(name, rdata, exp);
    endtask

    // Advance one clock: update the model from the current inputs, then
    // compare every visible output 1ns after the edge.
    task automatic cycle();
        logic [31:0] cnt;
        logic        win, n_ti;
        cnt  = m_count();
        win  = mtc0_we && !exc_valid && !eret;
        n_ti = (win && rd == 5'd11) ? 1'b0 : ((cnt == m_compare) ? 1'b1 : m_ti);
        if (win && rd == 5'd9) begin
            m_base = wdata;
            m_cyc  = 0;
        end else begin
            m_cyc++;
        end
        if (win && rd == 5'd11) m_compare = wdata;
        m_ti = n_ti;
        if (exc_valid) begin
            if (!m_status[1]) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_bd  = exc_bd;
            end
            m_status[1] = 1'b1;
            m_code      = exc_code;
            if (exc_bv_we) m_badv = exc_bv;
        end else if (eret) begin
            m_status[1] = 1'b0;
        end else if (mtc0_we) begin
            case (rd)
                5'd12:   m_status = wdata & 32'h0040_FF03;
                5'd13:   m_sw     = wdata[9:8];
                5'd14:   m_epc    = wdata;
                default: ;
            endcase
        end
        m_hw = hw_int;
        @(posedge clk);
        #1;
        check32("int_req", {31'd0, int_req}, {31'd0, m_int()});
        check32("epc",     epc_out,    m_epc);
        check32("status",  status_out, m_status);
        check32("cause",   cause_out,  m_cause());
        check32("rdata",   rdata,      m_read(rd));
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        idle(); mtc0_we = 1'b1; rd = r; wdata = d;
        cycle();
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic bvwe, input logic [31:0] bv);
        idle(); exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
        exc_bv_we = bvwe; exc_bv = bv;
        cycle();
    endtask

    logic [4:0] rd_pool [9];

    initial begin
        rd_pool = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd10, 5'd31};
        rst_n = 1'b0;
        hw_int = 6'b0;
        idle();
        model_reset();
        #7;
        // Reset state
        peek("rst_status", 5'd12, 32'h0040_0000);
        peek("rst_compare", 5'd11, 32'hFFFF_FFFF);
        peek("rst_count", 5'd9, 32'h0000_0000);
        check32("rst_int_req", {31'd0, int_req}, 32'd0);
        check32("rst_cause", cause_out, 32'h0);
        rst_n = 1'b1;
        idle();

        // Timer: Compare=5, Count=0, Status IE|IM7
        mtc0(5'd11, 32'd5);
        mtc0(5'd9,  32'd0);
        mtc0(5'd12, 32'h0000_8001);
        for (int k = 2; k <= 10; k++) begin
            idle(); cycle();
        end
        peek("timer_count5", 5'd9, 32'd5);
        check32("timer_ti_not_yet", {31'd0, cause_out[30]}, 32'd0);
        idle(); cycle();
        check32("timer_ti_set", {31'd0, cause_out[30]}, 32'd1);
        check32("timer_int_req", {31'd0, int_req}, 32'd1);
        mtc0(5'd11, 32'h0000_1000);
        check32("timer_ti_clr", {31'd0, cause_out[30]}, 32'd0);
        check32("timer_int_clr", {31'd0, int_req}, 32'd0);

        // Cause write mask
        mtc0(5'd13, 32'hFFFF_FFFF);
        check32("cause_wmask", cause_out, 32'h0000_0300);
        mtc0(5'd13, 32'h0000_0000);

        // Exception in delay slot with BadVAddr capture
        exc(5'd4, 32'h0040_0010, 1'b1, 1'b1, 32'h0000_0003);
        check32("exc_epc", epc_out, 32'h0040_000C);
        check32("exc_cause", cause_out, 32'h8000_0010);
        check32("exc_status", status_out, 32'h0000_8003);
        peek("exc_badvaddr", 5'd8, 32'h0000_0003);

        // Nested exception keeps EPC/BD, updates ExcCode
        exc(5'd12, 32'h0040_0100, 1'b0, 1'b0, 32'h0);
        check32("nest_epc", epc_out, 32'h0040_000C);
        check32("nest_cause", cause_out, 32'h8000_0030);
        idle(); eret = 1'b1; cycle();
        check32("eret_status", status_out, 32'h0000_8001);

        // Exception + ERET + MTC0 Status=0 in one cycle
        idle(); exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h0040_0200;
        eret = 1'b1; mtc0_we = 1'b1; rd = 5'd12; wdata = 32'h0;
        cycle();
        check32("prio_status", status_out, 32'h0000_8003);
        check32("prio_epc", epc_out, 32'h0040_0200);
        idle(); eret = 1'b1; cycle();

        // Hardware interrupt line 0
        mtc0(5'd12, 32'h0000_0401);
        idle(); hw_int = 6'b000001; cycle();
        check32("hw_cause", cause_out, 32'h0000_0420);
        check32("hw_int_req", {31'd0, int_req}, 32'd1);
        hw_int = 6'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            rd = rd_pool[$urandom_range(0, 8)];
            wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            mtc0_we   = ($urandom_range(0, 3) == 0);
            eret      = ($urandom_range(0, 9) == 0);
            exc_valid = ($urandom_range(0, 14) == 0);
            exc_code  = 5'($urandom_range(0, 31));
            exc_pc    = $urandom;
            exc_bd    = 1'($urandom_range(0, 1));
            exc_bv_we = 1'($urandom_range(0, 1));
            exc_bv    = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
            cycle();

            // Asynchronous reset mid-run, away from the clock edge
            if (n == 1500) begin
                #2;
                rst_n = 1'b0;
                hw_int = 6'b0;
                idle();
                model_reset();
                #1;
                check32("arst_status", status_out, 32'h0040_0000);
                check32("arst_epc", epc_out, 32'h0);
                check32("arst_cause", cause_out, 32'h0);
                check32("arst_int_req", {31'd0, int_req}, 32'd0);
                peek("arst_compare", 5'd11, 32'hFFFF_FFFF);
                peek("arst_count", 5'd9, 32'h0);
                peek("arst_badvaddr", 5'd8, 32'h0);
                rst_n = 1'b1;
                idle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
